// File: rtl/game2048_pkg.sv
// Shared 2048-game definitions: move-direction codes, game status codes and the
// direction_input FSM state type.
package game2048_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  localparam logic [1:0] GS_NOT_PLAYING = 2'b00;
  localparam logic [1:0] GS_PLAYING     = 2'b01;
  localparam logic [1:0] GS_WIN         = 2'b10;
  localparam logic [1:0] GS_LOSE        = 2'b11;

  typedef enum logic [1:0] {
    DI_RELEASE,
    DI_ARMED,
    DI_SEND,
    DI_WAIT_DONE
  } dir_state_t;

  // Press vector is ordered {right, left, down, up}; the lowest set bit wins.
  function automatic logic [3:0] pick_direction(input logic [3:0] press);
    logic [3:0] dir;
    dir = DIR_NONE;
    if (press[0])      dir = DIR_UP;
    else if (press[1]) dir = DIR_DOWN;
    else if (press[2]) dir = DIR_LEFT;
    else if (press[3]) dir = DIR_RIGHT;
    return dir;
  endfunction

endpackage

// File: rtl/direction_input_if.sv
// Button/game-status bundle between the board inputs, the game core and
// direction_input. The slave side is the direction_input block itself.
interface direction_input_if;

  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic [1:0] game_state;
  logic [3:0] direction;
  logic       busy;

  modport master (
    output btn_up,
    output btn_down,
    output btn_left,
    output btn_right,
    output game_state,
    input  direction,
    input  busy
  );

  modport slave (
    input  btn_up,
    input  btn_down,
    input  btn_left,
    input  btn_right,
    input  game_state,
    output direction,
    output busy
  );

endinterface

// File: rtl/button_debounce.sv
// One push button: 2-FF synchronizer, saturating-counter debouncer and a
// one-cycle rising-edge (press) detector on the debounced level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_syncActive
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_levelD;
  logic [CW-1:0] r_cnt;
  logic          w_synced;

  assign w_synced = r_sync[1];

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[0], i_btn};
  end

  // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching cycle;
  // any agreeing cycle restarts the count, so it can never run past CNT_LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (w_synced == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt >= CNT_LAST) begin
      r_level <= w_synced;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_levelD <= 1'b0;
    else     r_levelD <= r_level;
  end

  assign o_level      = r_level;
  assign o_press      = r_level & ~r_levelD;
  assign o_syncActive = r_sync[0] | r_sync[1];

endmodule

// File: rtl/direction_input.sv
// Turns four debounced push buttons into a one-hot move command for the 2048
// core, issuing one command per press and only while a game is being played.
module direction_input
  import game2048_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input logic              clk,
  input logic              rst,
  direction_input_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  dir_state_t    r_state;
  dir_state_t    w_nextState;
  logic [3:0]    r_direction;
  logic [3:0]    w_nextDir;
  logic          r_busy;
  logic          r_quiet;
  logic [TW-1:0] r_tcnt;

  logic [3:0] w_btnRaw;
  logic [3:0] w_level;
  logic [3:0] w_press;
  logic [3:0] w_syncActive;
  logic       w_allQuiet;
  logic       w_timeout;
  logic       w_playing;

  assign w_btnRaw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk          (clk),
      .rst          (rst),
      .i_btn        (w_btnRaw[g]),
      .o_level      (w_level[g]),
      .o_press      (w_press[g]),
      .o_syncActive (w_syncActive[g])
    );
  end

  // Arming also waits for the synchronizers to be empty for two cycles, so a
  // button held through reset cannot slip in before its level rises.
  assign w_allQuiet = ~|w_level & ~|w_syncActive;
  assign w_timeout  = (r_tcnt >= T_LAST);
  assign w_playing  = (bus.game_state == GS_PLAYING);

  always_ff @(posedge clk) begin
    if (rst) r_quiet <= 1'b0;
    else     r_quiet <= w_allQuiet;
  end

  always_ff @(posedge clk) begin
    if (rst || r_state != DI_SEND) r_tcnt <= '0;
    else if (!w_timeout)           r_tcnt <= r_tcnt + TW'(1);
  end

  always_comb begin
    w_nextState = r_state;
    w_nextDir   = r_direction;
    case (r_state)
      DI_RELEASE: begin
        w_nextDir = DIR_NONE;
        if (r_quiet && w_allQuiet) w_nextState = DI_ARMED;
      end
      DI_ARMED: begin
        if (|w_press) begin
          if (w_playing) begin
            w_nextState = DI_SEND;
            w_nextDir   = pick_direction(w_press);
          end else begin
            w_nextState = DI_RELEASE;
          end
        end
      end
      DI_SEND: begin
        if (!w_playing) begin
          w_nextState = DI_WAIT_DONE;
        end else if (w_timeout) begin
          w_nextState = DI_RELEASE;
          w_nextDir   = DIR_NONE;
        end
      end
      DI_WAIT_DONE: begin
        if (bus.game_state != GS_NOT_PLAYING) begin
          w_nextState = DI_RELEASE;
          w_nextDir   = DIR_NONE;
        end
      end
      default: begin
        w_nextState = DI_RELEASE;
        w_nextDir   = DIR_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= DI_RELEASE;
      r_direction <= DIR_NONE;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_nextState;
      r_direction <= w_nextDir;
      r_busy      <= (w_nextState != DI_ARMED);
    end
  end

  assign bus.direction = r_direction;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_direction_input.sv
// Directed bench for direction_input with short debounce/timeout settings;
// every scenario task drives buttons/game status and checks outputs inline.
module tb_direction_input;

  logic clk = 1'b0;
  logic rst;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cmdCount    = 0;
  logic [3:0] prevDir = 4'b0000;

  direction_input_if bus ();

  direction_input #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Counts commands as rising edges of a non-zero direction.
  always @(negedge clk) begin
    if (prevDir == 4'b0000 && bus.direction != 4'b0000) cmdCount++;
    prevDir = bus.direction;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic waitDir(input int maxCycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge clk);
      if (bus.direction !== 4'b0000) seen = 1'b1;
    end
  endtask

  task automatic waitArmed(input int maxCycles, output bit armed);
    armed = 1'b0;
    for (int i = 0; i < maxCycles && !armed; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) armed = 1'b1;
    end
  endtask

  task automatic releaseAll();
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
  endtask

  task automatic test_reset();
    bit armed;
    rst = 1'b1;
    releaseAll();
    bus.game_state = 2'b00;
    repeat (3) @(negedge clk);
    testsRun++;
    if (bus.direction !== 4'b0000) begin
      testsFailed++; $display("[TB] FAIL reset_dir: got %b, expected 0000", bus.direction);
    end
    testsRun++;
    if (bus.busy !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL reset_busy: got %b, expected 1", bus.busy);
    end
    rst = 1'b0;
    waitArmed(10, armed);
    testsRun++;
    if (armed !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL reset_arm: busy got %b, expected 0 within 10 cycles", bus.busy);
    end
  endtask

  task automatic test_glitch();
    int bad = 0;
    bus.game_state = 2'b01;
    @(negedge clk);
    bus.btn_up = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn_up = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.direction !== 4'b0000 || bus.busy !== 1'b0) bad++;
    end
    testsRun++;
    if (bad !== 0) begin
      testsFailed++; $display("[TB] FAIL glitch_ignored: %0d bad samples, expected 0 (dir %b busy %b)", bad, bus.direction, bus.busy);
    end
  endtask

  task automatic test_left_move();
    bit seen, armed;
    int startCnt;
    startCnt = cmdCount;
    bus.game_state = 2'b01;
    bus.btn_left = 1'b1;
    waitDir(15, seen);
    testsRun++;
    if (seen !== 1'b1 || bus.direction !== 4'b0100) begin
      testsFailed++; $display("[TB] FAIL left_dir: got %b, expected 0100", bus.direction);
    end
    bus.game_state = 2'b00;
    repeat (3) @(negedge clk);
    testsRun++;
    if (bus.direction !== 4'b0100) begin
      testsFailed++; $display("[TB] FAIL left_waitdone_hold: got %b, expected 0100", bus.direction);
    end
    bus.game_state = 2'b01;
    @(negedge clk);
    testsRun++;
    if (bus.direction !== 4'b0000 || bus.busy !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL left_done: dir %b busy %b, expected 0000 and 1", bus.direction, bus.busy);
    end
    repeat (3) @(negedge clk);
    testsRun++;
    if (bus.busy !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL left_busy_held: got %b, expected 1", bus.busy);
    end
    bus.btn_left = 1'b0;
    waitArmed(20, armed);
    testsRun++;
    if (armed !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL left_rearm: busy got %b, expected 0 within 20 cycles", bus.busy);
    end
    testsRun++;
    if (cmdCount - startCnt !== 1) begin
      testsFailed++; $display("[TB] FAIL left_once: got %0d commands, expected 1", cmdCount - startCnt);
    end
  endtask

  task automatic test_priority();
    bit seen, armed;
    bus.game_state = 2'b01;
    bus.btn_up = 1'b1;
    bus.btn_right = 1'b1;
    waitDir(15, seen);
    testsRun++;
    if (seen !== 1'b1 || bus.direction !== 4'b0001) begin
      testsFailed++; $display("[TB] FAIL prio_dir: got %b, expected 0001", bus.direction);
    end
    bus.game_state = 2'b11;
    @(negedge clk);
    testsRun++;
    if (bus.direction !== 4'b0001) begin
      testsFailed++; $display("[TB] FAIL prio_wait_held: got %b, expected 0001", bus.direction);
    end
    @(negedge clk);
    testsRun++;
    if (bus.direction !== 4'b0000) begin
      testsFailed++; $display("[TB] FAIL prio_lose_clear: got %b, expected 0000", bus.direction);
    end
    releaseAll();
    bus.game_state = 2'b01;
    waitArmed(20, armed);
    testsRun++;
    if (armed !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL prio_rearm: busy got %b, expected 0 within 20 cycles", bus.busy);
    end
  endtask

  task automatic test_timeout();
    bit seen, armed;
    int len;
    bus.game_state = 2'b01;
    bus.btn_down = 1'b1;
    waitDir(15, seen);
    testsRun++;
    if (seen !== 1'b1 || bus.direction !== 4'b0010) begin
      testsFailed++; $display("[TB] FAIL timeout_dir: got %b, expected 0010", bus.direction);
    end
    len = seen ? 1 : 0;
    for (int i = 0; i < 40 && seen; i++) begin
      @(negedge clk);
      if (bus.direction === 4'b0010) len++;
      else seen = 1'b0;
    end
    testsRun++;
    if (len !== 16) begin
      testsFailed++; $display("[TB] FAIL timeout_len: command held %0d cycles, expected 16", len);
    end
    testsRun++;
    if (bus.direction !== 4'b0000 || bus.busy !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL timeout_release: dir %b busy %b, expected 0000 and 1", bus.direction, bus.busy);
    end
    bus.btn_down = 1'b0;
    waitArmed(20, armed);
    testsRun++;
    if (armed !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL timeout_rearm: busy got %b, expected 0 within 20 cycles", bus.busy);
    end
  endtask

  task automatic test_not_playing();
    bit seen, armed;
    int bad = 0;
    bus.game_state = 2'b00;
    bus.btn_down = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.direction !== 4'b0000) bad++;
    end
    testsRun++;
    if (bad !== 0 || bus.busy !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL np_dropped: %0d command samples, busy %b, expected 0 and 1", bad, bus.busy);
    end
    bus.game_state = 2'b01;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.direction !== 4'b0000) bad++;
    end
    testsRun++;
    if (bad !== 0 || bus.busy !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL np_held_blocked: %0d command samples, busy %b, expected 0 and 1", bad, bus.busy);
    end
    bus.btn_down = 1'b0;
    waitArmed(20, armed);
    testsRun++;
    if (armed !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL np_rearm: busy got %b, expected 0 within 20 cycles", bus.busy);
    end
    bus.btn_down = 1'b1;
    waitDir(15, seen);
    testsRun++;
    if (seen !== 1'b1 || bus.direction !== 4'b0010) begin
      testsFailed++; $display("[TB] FAIL np_repress_dir: got %b, expected 0010", bus.direction);
    end
    bus.game_state = 2'b10;
    repeat (3) @(negedge clk);
    testsRun++;
    if (bus.direction !== 4'b0000) begin
      testsFailed++; $display("[TB] FAIL np_win_clear: got %b, expected 0000", bus.direction);
    end
    bus.btn_down = 1'b0;
    bus.game_state = 2'b01;
    waitArmed(20, armed);
  endtask

  task automatic test_reset_mid();
    bit seen, armed;
    int bad = 0;
    bus.game_state = 2'b01;
    bus.btn_right = 1'b1;
    waitDir(15, seen);
    testsRun++;
    if (seen !== 1'b1 || bus.direction !== 4'b1000) begin
      testsFailed++; $display("[TB] FAIL rm_dir: got %b, expected 1000", bus.direction);
    end
    bus.game_state = 2'b00;
    repeat (2) @(negedge clk);
    testsRun++;
    if (bus.direction !== 4'b1000) begin
      testsFailed++; $display("[TB] FAIL rm_waitdone_held: got %b, expected 1000", bus.direction);
    end
    rst = 1'b1;
    @(negedge clk);
    testsRun++;
    if (bus.direction !== 4'b0000 || bus.busy !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL rm_reset: dir %b busy %b, expected 0000 and 1", bus.direction, bus.busy);
    end
    rst = 1'b0;
    bus.game_state = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.direction !== 4'b0000 || bus.busy !== 1'b1) bad++;
    end
    testsRun++;
    if (bad !== 0) begin
      testsFailed++; $display("[TB] FAIL rm_held_blocked: %0d bad samples, expected 0 (dir %b busy %b)", bad, bus.direction, bus.busy);
    end
    bus.btn_right = 1'b0;
    waitArmed(20, armed);
    testsRun++;
    if (armed !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL rm_rearm: busy got %b, expected 0 within 20 cycles", bus.busy);
    end
    bus.btn_right = 1'b1;
    waitDir(15, seen);
    testsRun++;
    if (seen !== 1'b1 || bus.direction !== 4'b1000) begin
      testsFailed++; $display("[TB] FAIL rm_repress: got %b, expected 1000", bus.direction);
    end
    bus.game_state = 2'b11;
    repeat (3) @(negedge clk);
    bus.btn_right = 1'b0;
    bus.game_state = 2'b01;
    waitArmed(20, armed);
  endtask

  initial begin
    rst = 1'b1;
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    bus.game_state = 2'b00;
    test_reset();
    test_glitch();
    test_left_move();
    test_priority();
    test_timeout();
    test_not_playing();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
